// File: rtl/mult_ctrl.sv
// Two-requester arbiter/sequencer in front of a sequential multiplier.
// Optional WAIT watchdog is enabled by defining MULT_CTRL_TIMEOUT_EN.
module mult_ctrl #(
    parameter int W       = 5,
    parameter int TIMEOUT = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             req0_valid,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic             req1_valid,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    output logic             req0_ready,
    output logic             req1_ready,
    output logic             mul_start,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    input  logic             mul_done,
    input  logic [2*W-1:0]   mul_p,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [2*W-1:0]   resp_result,
    output logic             resp_err,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // Handshakes: a transfer happens in a cycle where valid && ready are both 1.
    // reqN_ready is only ever high in IDLE; resp_valid is high for all of RESP.
    logic [1:0] state;
    logic       last_grant;
    logic       req_hs;
    logic       tmo_hit;

    // Round-robin tie break: the requester not served last wins a tie.
    assign req0_ready = (state == S_IDLE) && req0_valid && (!req1_valid || last_grant);
    assign req1_ready = (state == S_IDLE) && req1_valid && (!req0_valid || !last_grant);
    assign req_hs     = req0_ready || req1_ready;

    assign mul_start  = (state == S_START);
    assign resp_valid = (state == S_RESP);
    assign busy       = (state != S_IDLE);
    assign state_dbg  = state;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state       <= S_IDLE;
            last_grant  <= 1'b1;
            mul_a       <= '0;
            mul_b       <= '0;
            resp_id     <= 1'b0;
            resp_result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_hs) begin
                        mul_a      <= req1_ready ? req1_a : req0_a;
                        mul_b      <= req1_ready ? req1_b : req0_b;
                        resp_id    <= req1_ready;
                        last_grant <= req1_ready;
                        state      <= S_START;
                    end
                end
                S_START: state <= S_WAIT;
                S_WAIT: begin
                    if (mul_done) begin
                        resp_result <= mul_p;
                        state       <= S_RESP;
                    end else if (tmo_hit) begin
                        resp_result <= '0;
                        state       <= S_RESP;
                    end
                end
                default: begin
                    if (resp_ready) state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MULT_CTRL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] tmo_cnt;

    // The last permitted WAIT cycle is the one where the count reads TIMEOUT-1;
    // a mul_done in that same cycle still wins.
    assign tmo_hit = (state == S_WAIT) && !mul_done && (tmo_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            tmo_cnt  <= '0;
            resp_err <= 1'b0;
        end else begin
            if (state == S_START) begin
                tmo_cnt <= '0;
            end else if (state == S_WAIT && !mul_done) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (state == S_WAIT) begin
                if (mul_done) begin
                    resp_err <= 1'b0;
                end else if (tmo_hit) begin
                    resp_err <= 1'b1;
                end
            end
        end
    end
`else
    assign tmo_hit  = 1'b0;
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl: vector table of transactions, scoreboard of expected
// responses, and hand-written reset / timeout sequences.
`timescale 1ns/1ps
module tb_mult_ctrl;

    localparam int W       = 5;
    localparam int TIMEOUT = 16;
    localparam int RW      = 2*W + 2;

    logic           clk;
    logic           rst_n;
    logic           req0_valid, req1_valid;
    logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic           req0_ready, req1_ready;
    logic           mul_start;
    logic [W-1:0]   mul_a, mul_b;
    logic           mul_done;
    logic [2*W-1:0] mul_p;
    logic           resp_valid, resp_ready, resp_id, resp_err, busy;
    logic [2*W-1:0] resp_result;
    logic [1:0]     state_dbg;

    mult_ctrl #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_p(mul_p),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_err(resp_err),
        .busy(busy), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic           v0;
        logic [W-1:0]   a0, b0;
        logic           v1;
        logic [W-1:0]   a1, b1;
        int             k;
        int             hold;
        logic           exp_id;
        logic [2*W-1:0] exp_res;
    } vec_t;

    vec_t          vecs[6];
    logic [RW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_resp(input string tag);
        logic [RW-1:0] e;
        check({tag, "_valid"}, resp_valid, 1);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_sb: got response with empty expected queue", tag);
        end else begin
            e = exp_q[0];
            check({tag, "_id"}, resp_id, e[RW-1]);
            check({tag, "_err"}, resp_err, e[RW-2]);
            check({tag, "_result"}, resp_result, e[2*W-1:0]);
        end
    endtask

    // Driver: one full transaction; must be entered at posedge+1.
    task automatic do_txn(input vec_t v);
        logic [W-1:0]   ea, eb;
        logic [2*W-1:0] prod;
        ea   = v.exp_id ? v.a1 : v.a0;
        eb   = v.exp_id ? v.b1 : v.b0;
        prod = {{W{1'b0}}, ea} * {{W{1'b0}}, eb};
        req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0;
        req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1;
        @(negedge clk);
        check("ready0", req0_ready, !v.exp_id);
        check("ready1", req1_ready, v.exp_id);
        check("ready_excl", req0_ready && req1_ready, 0);
        exp_q.push_back({v.exp_id, 1'b0, v.exp_res});
        tick();
        @(negedge clk);
        check("start_pulse", mul_start, 1);
        check("start_state", state_dbg, 1);
        check("mul_a", mul_a, ea);
        check("mul_b", mul_b, eb);
        check("busy_start", busy, 1);
        check("ready_start", req0_ready || req1_ready, 0);
        tick();
        for (int i = 2; i < v.k; i++) begin
            @(negedge clk);
            check("wait_no_resp", resp_valid, 0);
            check("wait_no_start", mul_start, 0);
            check("wait_ready", req0_ready || req1_ready, 0);
            tick();
        end
        mul_done = 1'b1;
        mul_p    = prod;
        tick();
        mul_done = 1'b0;
        mul_p    = (2*W)'($urandom);
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            check_resp("resp_hold");
            check("hold_ready", req0_ready || req1_ready, 0);
            mul_done = (i % 2 == 0);
            mul_p    = (2*W)'($urandom);
            tick();
        end
        mul_done   = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        check_resp("resp_hs");
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        logic lg;
        vec_t rv;

        vecs[0] = '{1'b1, 5'd5,  5'd7,  1'b0, 5'd0,  5'd0,  6,  0, 1'b0, 10'd35};
        vecs[1] = '{1'b0, 5'd0,  5'd0,  1'b1, 5'd31, 5'd31, 3,  4, 1'b1, 10'd961};
        vecs[2] = '{1'b1, 5'd3,  5'd4,  1'b1, 5'd6,  5'd2,  2,  1, 1'b0, 10'd12};
        vecs[3] = '{1'b1, 5'd3,  5'd4,  1'b1, 5'd7,  5'd2,  4,  0, 1'b1, 10'd14};
        vecs[4] = '{1'b1, 5'd31, 5'd1,  1'b0, 5'd0,  5'd0,  2,  2, 1'b0, 10'd31};
        vecs[5] = '{1'b1, 5'd0,  5'd9,  1'b1, 5'd9,  5'd9,  17, 0, 1'b1, 10'd81};

        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        mul_done = 0; mul_p = 0; resp_ready = 0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_state", state_dbg, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_mul_start", mul_start, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int n = 0; n < 6; n++) do_txn(vecs[n]);

        // Abort a WAIT with reset; the late mul_done must produce nothing.
        req0_valid = 1; req0_a = 5'd4; req0_b = 5'd4; req1_valid = 0;
        @(negedge clk);
        check("abort_ready0", req0_ready, 1);
        tick();
        req0_valid = 0;
        tick();
        tick();
        @(negedge clk);
        check("abort_in_wait", state_dbg, 2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_mul_start", mul_start, 0);
        check("arst_mul_a", mul_a, 0);
        check("arst_mul_b", mul_b, 0);
        check("arst_resp_valid", resp_valid, 0);
        check("arst_resp_id", resp_id, 0);
        check("arst_resp_result", resp_result, 0);
        check("arst_resp_err", resp_err, 0);
        mul_done = 1; mul_p = 10'd99;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("late_done_resp", resp_valid, 0);
            check("late_done_busy", busy, 0);
            tick();
        end
        mul_done = 0;

        // Both requesters held after reset: grants 0,1,0.
        for (int n = 0; n < 3; n++) begin
            rv = '{1'b1, 5'd2, 5'd3, 1'b1, 5'd4, 5'd5, 2 + n, n, 1'b0, 10'd6};
            rv.exp_id  = (n == 1);
            rv.exp_res = (n == 1) ? 10'd20 : 10'd6;
            do_txn(rv);
        end
        lg = 1'b0;

        for (int n = 0; n < 8; n++) begin
            rv.v0 = 1'($urandom_range(0, 1));
            rv.v1 = rv.v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            rv.a0 = W'($urandom_range(0, 31)); rv.b0 = W'($urandom_range(0, 31));
            rv.a1 = W'($urandom_range(0, 31)); rv.b1 = W'($urandom_range(0, 31));
            rv.k    = $urandom_range(2, 8);
            rv.hold = $urandom_range(0, 3);
            rv.exp_id = (rv.v0 && (!rv.v1 || lg)) ? 1'b0 : 1'b1;
            rv.exp_res = rv.exp_id ? {{W{1'b0}}, rv.a1} * {{W{1'b0}}, rv.b1}
                                   : {{W{1'b0}}, rv.a0} * {{W{1'b0}}, rv.b0};
            lg = rv.exp_id;
            do_txn(rv);
        end

        // mul_done never arrives.
        req0_valid = 1; req0_a = 5'd2; req0_b = 5'd3; req1_valid = 0;
        @(negedge clk);
        check("tmo_ready0", req0_ready, 1);
        tick();
        req0_valid = 0;
        @(negedge clk);
        check("tmo_start", mul_start, 1);
        tick();
`ifdef MULT_CTRL_TIMEOUT_EN
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            check("tmo_wait", resp_valid, 0);
            tick();
        end
        exp_q.push_back({1'b0, 1'b1, 10'd0});
`else
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("notmo_busy", busy, 1);
            check("notmo_no_resp", resp_valid, 0);
            tick();
        end
        mul_done = 1; mul_p = 10'd6;
        exp_q.push_back({1'b0, 1'b0, 10'd6});
        tick();
        mul_done = 0;
`endif
        @(negedge clk);
        check_resp("tmo_resp");
        resp_ready = 1;
        @(negedge clk);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        tick();
        resp_ready = 0;
        @(negedge clk);
        check("final_idle", busy, 0);
        check("final_sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_ctrl.md
MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 5, meaning operand width in bits; the product is 2*W bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum cycles spent waiting for mul_done; it is used only when MULT_CTRL_TIMEOUT_EN is defined.
REQ-003 The block SHALL have port wb_clk_i, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port wb_rst_ni, input, 1 bit, an asynchronous active-low reset.
REQ-005 The block SHALL have ports req0_valid and req1_valid, input, 1 bit each, meaning requester n has operands pending.
REQ-006 The block SHALL have ports req0_a, req0_b, req1_a and req1_b, input, W bits each, meaning the operands of requester n.
REQ-007 The block SHALL have ports req0_ready and req1_ready, output, 1 bit each, meaning the request from requester n is accepted this cycle.
REQ-008 The block SHALL have port mul_start, output, 1 bit, a one-cycle start pulse to the sequential multiplier.
REQ-009 The block SHALL have ports mul_a and mul_b, output, W bits each, the registered operands driven to the multiplier.
REQ-010 The block SHALL have ports mul_done (input, 1 bit, product valid) and mul_p (input, 2*W bits, product).
REQ-011 The block SHALL have ports resp_valid (output, 1), resp_ready (input, 1), resp_id (output, 1, requester index), resp_result (output, 2*W) and resp_err (output, 1, timeout flag).
REQ-012 The block SHALL have port busy, output, 1 bit, asserted whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, START, WAIT and RESP.
- IDLE->START on a request handshake.
- START->WAIT unconditionally after one cycle.
- WAIT->RESP on mul_done, or on timeout.
- RESP->IDLE when resp_valid && resp_ready.
REQ-014 In IDLE, reqN_ready SHALL be combinational: ready0 = valid0 && (!valid1 || last_grant==1) and ready1 = valid1 && (!valid0 || last_grant==0); both readies SHALL be 0 outside IDLE.
REQ-015 On handshake, the block SHALL register the operands into mul_a/mul_b, the index into resp_id and last_grant, all at the same edge.
REQ-016 mul_start SHALL be 1 for exactly the START cycle, i.e. the cycle after the handshake, with mul_a/mul_b stable from START until the next handshake.
REQ-017 In WAIT, on mul_done=1 the block SHALL capture mul_p into resp_result, clear resp_err, and enter RESP on the next edge.
REQ-018 mul_done SHALL be ignored in IDLE, START and RESP.
REQ-019 In RESP, resp_valid SHALL be 1 and resp_id, resp_result and resp_err SHALL be held stable until resp_ready; the handshake cycle returns to IDLE, and a new request is accepted no earlier than the following cycle.
REQ-020 The minimum latency SHALL be: handshake at cycle 0, mul_start at 1, mul_done at k >= 2 gives resp_valid at k+1.
REQ-021 With a single requester valid, it SHALL be granted regardless of last_grant.
REQ-022 No request SHALL be dropped: a requester holding valid is granted within two transactions.

Reset
REQ-023 While wb_rst_ni=0, the block SHALL immediately force state=IDLE and set mul_start, mul_a, mul_b, resp_valid, resp_id, resp_result, resp_err, busy and the timeout counter to 0, and last_grant to 1 so requester 0 wins the first tie.
REQ-024 A reset during START, WAIT or RESP SHALL abort the transaction with no response produced, and a later mul_done for it SHALL be ignored.

Configuration
REQ-025 With MULT_CTRL_TIMEOUT_EN defined, a counter SHALL clear on START and increment each WAIT cycle; if it reaches TIMEOUT with no mul_done, the block SHALL enter RESP with resp_result=0 and resp_err=1, and mul_done in that same cycle SHALL take priority (resp_err=0).
REQ-026 Without MULT_CTRL_TIMEOUT_EN, there SHALL be no counter, resp_err SHALL be constant 0, and WAIT SHALL persist until mul_done.

Verification
REQ-027 The bench SHALL cover: req0 5x7, mul_done after 6 cycles -> one mul_start with mul_a=5 and mul_b=7; resp_valid with resp_id=0, resp_result=35, resp_err=0.
REQ-028 The bench SHALL cover: req0 and req1 valid together after reset, both held -> grants alternate 0,1,0; ready0 and ready1 never high in the same cycle.
REQ-029 The bench SHALL cover: req1 31x31 with resp_ready low for 4 cycles -> resp_result=961 and resp_id=1 held stable all 4 cycles; ready0/1 stay 0 until return to IDLE.
REQ-030 The bench SHALL cover: TIMEOUT=16 with MULT_CTRL_TIMEOUT_EN and mul_done never asserted -> resp_err=1 and resp_result=0 exactly 16 WAIT cycles after START; without the macro, busy stays 1.
REQ-031 The bench SHALL cover: wb_rst_ni pulsed low during WAIT, then mul_done=1 -> all outputs 0 asynchronously, no resp_valid, and the next tie is granted to req0.
